// File: rtl/sobel_stream_if.sv
// Pixel-stream bundle for the Sobel edge detector: raster input with
// frame marker and runtime controls, plus the result stream.
interface sobel_stream_if #(
    parameter int DW = 8
);
    logic [DW-1:0] pix_in;
    logic          pix_valid;
    logic          sof;
    logic [1:0]    mode;
    logic [DW+2:0] threshold;
    logic [DW-1:0] edge_out;
    logic          edge_valid;

    // Pixel source / result sink side
    modport master (
        output pix_in, pix_valid, sof, mode, threshold,
        input  edge_out, edge_valid
    );

    // Edge-detector side
    modport slave (
        input  pix_in, pix_valid, sof, mode, threshold,
        output edge_out, edge_valid
    );
endinterface

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector. Builds the window from two line
// buffers and three column shift registers, then computes Gx/Gy, their
// magnitudes and a mode-selected output over a 4-register pipeline.
module sobel_stream #(
    parameter int DW         = 8,
    parameter int LINE_WIDTH = 640,
    parameter int ROW_BITS   = 10,
    parameter int MAG_SHIFT  = 2
) (
    input logic          clock,
    input logic          reset_n,
    sobel_stream_if.slave bus
);
    localparam int              CW       = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int              GW       = DW + 3;
    localparam logic [CW-1:0]   COL_LAST = CW'(LINE_WIDTH - 1);
    localparam logic [DW-1:0]   PIX_MAX  = '1;

    // Zero-extend a pixel into the signed gradient width.
    function automatic logic signed [GW-1:0] ext(input logic [DW-1:0] p);
        return signed'({3'b000, p});
    endfunction

    // Position counters
    logic [CW-1:0]       col_q, col_d, cur_col;
    logic [ROW_BITS-1:0] row_q, row_d, cur_row;
    logic                win_done;

    // Line buffers (row r-1 and row r-2) and their read ports
    logic [DW-1:0] lb1_mem [LINE_WIDTH];
    logic [DW-1:0] lb2_mem [LINE_WIDTH];
    logic [DW-1:0] lb1_rd, lb2_rd;

    // S1: window
    logic [DW-1:0] z_q [9];
    logic [DW-1:0] z_d [9];
    logic          s1_valid_q, s1_valid_d, s1_cmp_q, s1_cmp_d;

    // S2: signed gradients
    logic signed [GW-1:0] gx_q, gx_d, gy_q, gy_d;
    logic                 s2_valid_q, s2_valid_d, s2_cmp_q, s2_cmp_d;

    // S3: magnitudes
    logic [DW+1:0] agx_q, agx_d, agy_q, agy_d;
    logic [GW-1:0] sum_q, sum_d;
    logic          s3_valid_q, s3_valid_d, s3_cmp_q, s3_cmp_d;

    // S4: output
    logic [GW-1:0] sum_sh;
    logic [DW-1:0] sel;
    logic [DW-1:0] edge_out_q, edge_out_d;
    logic          edge_valid_q, edge_valid_d;

    // Resolve the current pixel position (sof forces 0,0) and advance counters
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        cur_col = bus.sof ? '0 : col_q;
        cur_row = bus.sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (bus.pix_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (&cur_row) ? cur_row : cur_row + ROW_BITS'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
        win_done = (cur_row >= ROW_BITS'(2)) && (cur_col >= CW'(2));
        lb1_rd   = lb1_mem[cur_col];
        lb2_rd   = lb2_mem[cur_col];
    end

    // Shift the newest column into the window on each accepted pixel
    always_comb begin
        z_d        = z_q;
        s1_cmp_d   = s1_cmp_q;
        s1_valid_d = bus.pix_valid;
        if (bus.pix_valid) begin
            z_d[0]   = z_q[1];
            z_d[1]   = z_q[2];
            z_d[2]   = lb2_rd;
            z_d[3]   = z_q[4];
            z_d[4]   = z_q[5];
            z_d[5]   = lb1_rd;
            z_d[6]   = z_q[7];
            z_d[7]   = z_q[8];
            z_d[8]   = bus.pix_in;
            s1_cmp_d = win_done;
        end
    end

    // Horizontal and vertical Sobel gradients of the held window
    always_comb begin
        gx_d = (ext(z_q[2]) - ext(z_q[0]))
             + ((ext(z_q[5]) - ext(z_q[3])) <<< 1)
             + (ext(z_q[8]) - ext(z_q[6]));
        gy_d = (ext(z_q[0]) - ext(z_q[6]))
             + ((ext(z_q[1]) - ext(z_q[7])) <<< 1)
             + (ext(z_q[2]) - ext(z_q[8]));
        s2_valid_d = s1_valid_q;
        s2_cmp_d   = s1_cmp_q;
    end

    // Gradient magnitudes and their sum
    always_comb begin
        agx_d      = gx_q[GW-1] ? (DW+2)'(-gx_q) : (DW+2)'(gx_q);
        agy_d      = gy_q[GW-1] ? (DW+2)'(-gy_q) : (DW+2)'(gy_q);
        sum_d      = {1'b0, agx_d} + {1'b0, agy_d};
        s3_valid_d = s2_valid_q;
        s3_cmp_d   = s2_cmp_q;
    end

    // Mode select with clamping; incomplete windows yield 0, idle cycles hold
    always_comb begin
        sum_sh = sum_q >> MAG_SHIFT;
        sel    = '0;
        case (bus.mode)
            2'd0:    sel = (sum_q > bus.threshold) ? PIX_MAX : '0;
            2'd1:    sel = (sum_sh > GW'(PIX_MAX)) ? PIX_MAX : sum_sh[DW-1:0];
            2'd2:    sel = (agx_q > (DW+2)'(PIX_MAX)) ? PIX_MAX : agx_q[DW-1:0];
            default: sel = (agy_q > (DW+2)'(PIX_MAX)) ? PIX_MAX : agy_q[DW-1:0];
        endcase
        if (!s3_cmp_q) begin
            sel = '0;
        end
        edge_out_d   = s3_valid_q ? sel : edge_out_q;
        edge_valid_d = s3_valid_q;
    end

    // Pipeline and counter registers with synchronous reset
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset_n) begin
            col_q        <= '0;
            row_q        <= '0;
            for (int i = 0; i < 9; i++) z_q[i] <= '0;
            s1_valid_q   <= 1'b0;
            s1_cmp_q     <= 1'b0;
            gx_q         <= '0;
            gy_q         <= '0;
            s2_valid_q   <= 1'b0;
            s2_cmp_q     <= 1'b0;
            agx_q        <= '0;
            agy_q        <= '0;
            sum_q        <= '0;
            s3_valid_q   <= 1'b0;
            s3_cmp_q     <= 1'b0;
            edge_out_q   <= '0;
            edge_valid_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            z_q          <= z_d;
            s1_valid_q   <= s1_valid_d;
            s1_cmp_q     <= s1_cmp_d;
            gx_q         <= gx_d;
            gy_q         <= gy_d;
            s2_valid_q   <= s2_valid_d;
            s2_cmp_q     <= s2_cmp_d;
            agx_q        <= agx_d;
            agy_q        <= agy_d;
            sum_q        <= sum_d;
            s3_valid_q   <= s3_valid_d;
            s3_cmp_q     <= s3_cmp_d;
            edge_out_q   <= edge_out_d;
            edge_valid_q <= edge_valid_d;
        end
    end

    // Line buffers: read-before-write at the current column
    always_ff @(posedge clock) begin
        // NOTE: line buffers are not reset; the row counter masks stale contents.
        if (reset_n && bus.pix_valid) begin
            lb1_mem[cur_col] <= bus.pix_in;
            lb2_mem[cur_col] <= lb1_rd;
        end
    end

    assign bus.edge_out   = edge_out_q;
    assign bus.edge_valid = edge_valid_q;
endmodule

// File: tb/tb_sobel_stream.sv
// Scoreboard bench for sobel_stream on an 8x8 frame: directed images with
// hand-derived gradients, a decoupled monitor checking value and latency.
module tb_sobel_stream;
    typedef enum int {FLAT, STEP, RAMP} img_t;
    typedef struct packed {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    logic [7:0] last_exp = 8'd0;
    logic [1:0] cur_mode;
    int         cur_thr;
    exp_t       q[$];

    sobel_stream_if #(.DW(8)) bus ();

    sobel_stream #(
        .DW(8), .LINE_WIDTH(8), .ROW_BITS(10), .MAG_SHIFT(2)
    ) dut (
        .clock  (clk),
        .reset_n(rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Test image pixels
    function automatic logic [7:0] pix_of(input img_t kind, input int c);
        case (kind)
            FLAT:    return 8'd100;
            STEP:    return (c < 4) ? 8'd0 : 8'd255;
            default: return 8'(20 * c);
        endcase
    endfunction

    // Hand-derived |Gx|,|Gy| per image, then the output rule (MAG_SHIFT=2)
    function automatic logic [7:0] exp_of(input img_t kind, input int r, input int c,
                                          input logic [1:0] m, input int thr);
        int agx, agy, sum, v;
        if (r < 2 || c < 2) return 8'd0;
        agx = 0;
        agy = 0;
        if (kind == STEP && (c == 4 || c == 5)) agx = 1020;
        if (kind == RAMP) agx = 160;
        sum = agx + agy;
        case (m)
            2'd0:    v = (sum > thr) ? 255 : 0;
            2'd1:    v = sum >> 2;
            2'd2:    v = agx;
            default: v = agy;
        endcase
        return 8'((v > 255) ? 255 : v);
    endfunction

    // Monitor: compare every presented result against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (bus.edge_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_valid: got edge_out=%0d with empty scoreboard (cycle %0d)",
                             bus.edge_out, cyc);
                end else begin
                    e = q.pop_front();
                    check("edge_out", 32'(bus.edge_out), 32'(e.data));
                    check("latency", 32'(cyc), 32'(e.due));
                    last_exp = e.data;
                end
            end else begin
                check("edge_valid_x", 32'(bus.edge_valid), 32'd0);
                check("hold", 32'(bus.edge_out), 32'(last_exp));
            end
        end
    end

    task automatic set_cfg(input logic [1:0] m, input int thr);
        cur_mode      = m;
        cur_thr       = thr;
        bus.mode      = m;
        bus.threshold = 11'(thr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.pix_valid = 1'b0;
            bus.sof       = 1'b0;
        end
    endtask

    // Drive one pixel; it is sampled at the next posedge (cyc+1), result 3 edges later
    task automatic send_pixel(input logic [7:0] p, input logic s, input logic [7:0] exp);
        @(negedge clk);
        bus.pix_in    = p;
        bus.pix_valid = 1'b1;
        bus.sof       = s;
        q.push_back('{exp, cyc + 4});
    endtask

    task automatic run_frame(input img_t kind, input bit gaps, input int npix);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (r * 8 + c < npix) begin
                    if (gaps && $urandom_range(1, 0) == 1) idle(1);
                    send_pixel(pix_of(kind, c), (r == 0 && c == 0),
                               exp_of(kind, r, c, cur_mode, cur_thr));
                end
            end
        end
    endtask

    task automatic drain();
        idle(1);
        for (int i = 0; i < 30; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.pix_in    = '0;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        set_cfg(2'd0, 160);
        repeat (3) @(negedge clk);
        check("reset_edge_valid", 32'(bus.edge_valid), 32'd0);
        check("reset_edge_out", 32'(bus.edge_out), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Flat frame: no edges anywhere
        run_frame(FLAT, 1'b0, 64);  drain();

        // Vertical step in each mode
        set_cfg(2'd0, 160); run_frame(STEP, 1'b0, 64); drain();
        set_cfg(2'd2, 160); run_frame(STEP, 1'b0, 64); drain();
        set_cfg(2'd3, 160); run_frame(STEP, 1'b0, 64); drain();
        set_cfg(2'd1, 160); run_frame(STEP, 1'b0, 64); drain();

        // Ramp: sum 160 sits exactly on the threshold boundary
        set_cfg(2'd0, 160); run_frame(RAMP, 1'b0, 64); drain();
        set_cfg(2'd0, 159); run_frame(RAMP, 1'b0, 64); drain();
        set_cfg(2'd1, 160); run_frame(RAMP, 1'b0, 64); drain();

        // Gapped step stream
        set_cfg(2'd0, 160); run_frame(STEP, 1'b1, 64); drain();

        // Reset in the middle of row 3, in-flight results are dropped
        run_frame(STEP, 1'b0, 28);
        @(negedge clk);
        rst_n         = 1'b0;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        @(posedge clk);
        q.delete();
        last_exp = 8'd0;
        @(negedge clk);
        check("midreset_valid", 32'(bus.edge_valid), 32'd0);
        check("midreset_out", 32'(bus.edge_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_reset_valid", 32'(bus.edge_valid), 32'd0);
        run_frame(STEP, 1'b0, 64); drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
